exec_alu_stage: RTL and testbench
=================================

Name: exec_alu_stage

Overview:
- Registered execute stage for the Y86-64 core; sits directly downstream of decode and drives the 64-bit ripple adder in the ALU.
- Selects ALU operands per icode and computes valE.
- Maintains the condition-code register (ZF/SF/OF) and evaluates cnd for cmovXX/jXX.
- Results are delivered through a one-entry valid/ready output register.

Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE.
- STACK_STEP, 8, byte adjustment applied to valB for push/pop/call/ret.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset; sampled on rising clk.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- valA  in  WIDTH  register operand A.
- valB  in  WIDTH  register operand B.
- valC  in  WIDTH  immediate/displacement.
- out_valid  out  1  result register holds a valid entry.
- out_ready  in  1  downstream (memory stage) accepts.
- valE  out  WIDTH  ALU result.
- cnd  out  1  condition outcome.
- err  out  1  invalid icode/ifun flagged for this entry.
- zf  out  1  current CC state (ZF).
- sf  out  1  current CC state (SF).
- of  out  1  current CC state (OF).

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0, valE=0, cnd=0, err=0, zf=1, sf=0, of=0. A reset mid-transfer discards the held entry; in_ready=1 from the following cycle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. The result appears at the next edge with out_valid=1; latency is 1 cycle.
  - Held entry stays stable while out_valid && !out_ready.
  - Simultaneous drain and accept gives full throughput, one instruction per cycle.
  - When out_ready=1 and there is no new accept, out_valid drops to 0.
- Operand/valE selection, evaluated at accept (all arithmetic mod 2^WIDTH):
  - 0 halt, 1 nop: valE=0.
  - 2 rrmovq/cmovXX: valE=valA.
  - 3 irmovq: valE=valC.
  - 4 rmmovq, 5 mrmovq: valE=valB+valC.
  - 6 OPq, per ifun: 0 add → valB+valA; 1 sub → valB-valA; 2 and → valB&valA; 3 xor → valB^valA.
  - 7 jXX: valE=0.
  - 8 call, A pushq: valE=valB-STACK_STEP.
  - 9 ret, B popq: valE=valB+STACK_STEP.
- CC update, only on an accepted valid OPq with err=0:
  - ZF = (t==0).
  - SF = t[WIDTH-1].
  - OF for add: sign(valA)==sign(valB) && sign(t)!=sign(valB).
  - OF for sub: sign(valA)!=sign(valB) && sign(t)!=sign(valB).
  - OF for and/xor: 0.
  - No other icode modifies CC.
- cnd for icode 2 or 7 uses CC as held at the accept edge, which includes any OPq accepted in an earlier cycle. Per ifun:
  - 0 always: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - All other icodes: cnd=0.
- err=1 when any of the following holds: icode>0xB; OPq with ifun>3; icode 2/7 with ifun>6; icode 0,1,3,4,5,8,9,A,B with ifun!=0.
- With err=1: valE=0, cnd=0, CC unchanged, and the entry is still delivered with out_valid=1.
- No accept (in_valid=0 or in_ready=0): CC and the output register are unchanged except for the drain.

Test Plan:
- Reset, then accept OPq add (6/0) with valA=5, valB=7 → next cycle: out_valid=1, valE=12, zf=0, sf=0, of=0, err=0.
- OPq sub with valA=1, valB=0x8000000000000000 → valE=0x7FFFFFFFFFFFFFFF, of=1, sf=0, zf=0. Then jXX l (7/2) → cnd=1. Then jXX e (7/3) → cnd=0.
- Back-to-back xor of valA=valB=0x55 followed by cmovne (2/4) valA=9 on consecutive cycles with out_ready=1 → first entry zf=1 and valE=0; second entry valE=9, cnd=0; in_ready stays 1 throughout.
- pushq (A/0) with valB=0x100 and out_ready=0 for 3 cycles → valE=0xF8 held stable, in_ready=0; a new in_valid is not accepted until out_ready=1, and then it is accepted in the same cycle the entry drains.
- Invalid OPq ifun=5 with valA=1, valB=1 → err=1, valE=0, cnd=0, CC unchanged (zf=1 straight after reset). icode 0xC → err=1.
- Hold an entry (out_valid=1, out_ready=0), then assert rst_n=0 for one edge → out_valid=0, zf=1, sf=0, of=0, valE=0 on that edge; in_ready=1 the next cycle.

Source files
------------

// File: rtl/exec_alu_stage_if.sv
// Decode-to-execute-to-memory handshake bundle for the Y86-64 execute stage.
// The master side is the producer of instructions and the consumer of results.
interface exec_alu_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [WIDTH-1:0] valC;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] valE;
    logic             cnd;
    logic             err;
    logic             zf;
    logic             sf;
    logic             of;

    modport master (
        output in_valid, icode, ifun, valA, valB, valC, out_ready,
        input  in_ready, out_valid, valE, cnd, err, zf, sf, of
    );

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC, out_ready,
        output in_ready, out_valid, valE, cnd, err, zf, sf, of
    );
endinterface

// File: rtl/exec_alu_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition codes and cnd,
// with the result held in a one-entry valid/ready output register.
module exec_alu_stage #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8
) (
    input logic            clk,
    input logic            rst_n,
    exec_alu_stage_if.slave bus
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);
    localparam int               MSB  = WIDTH - 1;

    logic             out_valid_q;
    logic [WIDTH-1:0] vale_q;
    logic             cnd_q;
    logic             err_q;
    logic             zf_q;
    logic             sf_q;
    logic             of_q;

    logic             accept;
    logic             err_next;
    logic             cond_raw;
    logic             cnd_next;
    logic             cc_we;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] vale_raw;
    logic [WIDTH-1:0] vale_next;
    logic             of_next;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Decode legality, operand selection and condition evaluation against the
    // CC value currently held, i.e. before this instruction's own update.
    always_comb begin
        err_next = 1'b0;
        case (bus.icode)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
            4'h8, 4'h9, 4'hA, 4'hB: err_next = (bus.ifun != 4'd0);
            4'h6:                   err_next = (bus.ifun > 4'd3);
            4'h2, 4'h7:             err_next = (bus.ifun > 4'd6);
            default:                err_next = 1'b1;
        endcase

        alu_res = '0;
        of_next = 1'b0;
        case (bus.ifun[1:0])
            2'd0: begin
                alu_res = bus.valB + bus.valA;
                of_next = (bus.valA[MSB] == bus.valB[MSB]) && (alu_res[MSB] != bus.valB[MSB]);
            end
            2'd1: begin
                alu_res = bus.valB - bus.valA;
                of_next = (bus.valA[MSB] != bus.valB[MSB]) && (alu_res[MSB] != bus.valB[MSB]);
            end
            2'd2:    alu_res = bus.valB & bus.valA;
            default: alu_res = bus.valB ^ bus.valA;
        endcase

        vale_raw = '0;
        case (bus.icode)
            4'h2:       vale_raw = bus.valA;
            4'h3:       vale_raw = bus.valC;
            4'h4, 4'h5: vale_raw = bus.valB + bus.valC;
            4'h6:       vale_raw = alu_res;
            4'h8, 4'hA: vale_raw = bus.valB - STEP;
            4'h9, 4'hB: vale_raw = bus.valB + STEP;
            default:    vale_raw = '0;
        endcase

        cond_raw = 1'b0;
        case (bus.ifun)
            4'd0:    cond_raw = 1'b1;
            4'd1:    cond_raw = (sf_q ^ of_q) | zf_q;
            4'd2:    cond_raw = sf_q ^ of_q;
            4'd3:    cond_raw = zf_q;
            4'd4:    cond_raw = !zf_q;
            4'd5:    cond_raw = !(sf_q ^ of_q);
            4'd6:    cond_raw = !(sf_q ^ of_q) && !zf_q;
            default: cond_raw = 1'b0;
        endcase

        vale_next = err_next ? '0 : vale_raw;
        cnd_next  = !err_next && ((bus.icode == 4'h2) || (bus.icode == 4'h7)) && cond_raw;
        cc_we     = accept && (bus.icode == 4'h6) && !err_next;
    end

    // Output register and CC; a drain without a new accept only clears valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            vale_q      <= '0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            zf_q        <= 1'b1;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                vale_q      <= vale_next;
                cnd_q       <= cnd_next;
                err_q       <= err_next;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (cc_we) begin
                zf_q <= (alu_res == '0);
                sf_q <= alu_res[MSB];
                of_q <= of_next;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.valE      = vale_q;
    assign bus.cnd       = cnd_q;
    assign bus.err       = err_q;
    assign bus.zf        = zf_q;
    assign bus.sf        = sf_q;
    assign bus.of        = of_q;
endmodule

// File: tb/tb_exec_alu_stage.sv
// Randomised plus directed bench for exec_alu_stage: a driver pushes expected
// results from a behavioural Y86 model into a queue, a monitor pops and compares.
module tb_exec_alu_stage;
    localparam int WIDTH = 64;

    typedef struct {
        logic [63:0] vale;
        logic        cnd;
        logic        err;
        logic        zf;
        logic        sf;
        logic        of;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   failures;
    exp_t sb[$];

    logic m_zf, m_sf, m_of;
    logic exp_full;

    exec_alu_stage_if #(.WIDTH(WIDTH)) bus ();

    exec_alu_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Architectural meaning of each instruction, using a 65-bit signed sum
    // for overflow detection; updates the model CC as a side effect.
    function automatic exp_t modelStep(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        exp_t e;
        logic legal;
        logic signed [64:0] s;
        logic less;
        legal = ((ic inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) && fn == 4'd0)
             || (ic == 4'h6 && fn <= 4'd3)
             || ((ic == 4'h2 || ic == 4'h7) && fn <= 4'd6);
        e.err  = !legal;
        e.vale = 64'd0;
        e.cnd  = 1'b0;
        less   = (m_sf != m_of);
        if (legal) begin
            case (ic)
                4'h2: e.vale = a;
                4'h3: e.vale = c;
                4'h4, 4'h5: e.vale = b + c;
                4'h8, 4'hA: e.vale = b - 64'd8;
                4'h9, 4'hB: e.vale = b + 64'd8;
                4'h6: begin
                    s = 65'sd0;
                    if (fn == 4'd0) s = $signed({b[63], b}) + $signed({a[63], a});
                    if (fn == 4'd1) s = $signed({b[63], b}) - $signed({a[63], a});
                    if (fn == 4'd2) e.vale = b & a;
                    else if (fn == 4'd3) e.vale = b ^ a;
                    else e.vale = s[63:0];
                    m_zf = (e.vale == 64'd0);
                    m_sf = e.vale[63];
                    m_of = (fn <= 4'd1) ? (s[64] != s[63]) : 1'b0;
                end
                default: e.vale = 64'd0;
            endcase
            if (ic == 4'h2 || ic == 4'h7) begin
                case (fn)
                    4'd0: e.cnd = 1'b1;
                    4'd1: e.cnd = less || m_zf;
                    4'd2: e.cnd = less;
                    4'd3: e.cnd = m_zf;
                    4'd4: e.cnd = !m_zf;
                    4'd5: e.cnd = !less;
                    default: e.cnd = !less && !m_zf;
                endcase
            end
        end
        e.zf = m_zf;
        e.sf = m_sf;
        e.of = m_of;
        return e;
    endfunction

    // One cycle of stimulus: drive after the edge, decide acceptance mid-cycle.
    task automatic applyStimulus(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                 input logic ordy);
        logic acc;
        bus.in_valid  = v;
        bus.icode     = ic;
        bus.ifun      = fn;
        bus.valA      = a;
        bus.valB      = b;
        bus.valC      = c;
        bus.out_ready = ordy;
        @(negedge clk);
        checkOutput("in_ready", {63'd0, bus.in_ready}, {63'd0, (!exp_full || ordy)});
        checkOutput("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_full});
        acc = v && (!exp_full || ordy);
        if (acc) sb.push_back(modelStep(ic, fn, a, b, c));
        @(posedge clk);
        #1;
        if (acc) exp_full = 1'b1;
        else if (ordy) exp_full = 1'b0;
    endtask

    task automatic doReset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst_valE", bus.valE, 64'd0);
        checkOutput("rst_zf", {63'd0, bus.zf}, 64'd1);
        checkOutput("rst_sf", {63'd0, bus.sf}, 64'd0);
        checkOutput("rst_of", {63'd0, bus.of}, 64'd0);
        checkOutput("rst_cnd", {63'd0, bus.cnd}, 64'd0);
        checkOutput("rst_err", {63'd0, bus.err}, 64'd0);
        rst_n    = 1'b1;
        sb.delete();
        m_zf     = 1'b1;
        m_sf     = 1'b0;
        m_of     = 1'b0;
        exp_full = 1'b0;
    endtask

    // Compare the held entry every cycle it is presented; pop on transfer.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                checkOutput("valE", bus.valE, sb[0].vale);
                checkOutput("cnd", {63'd0, bus.cnd}, {63'd0, sb[0].cnd});
                checkOutput("err", {63'd0, bus.err}, {63'd0, sb[0].err});
                checkOutput("zf", {63'd0, bus.zf}, {63'd0, sb[0].zf});
                checkOutput("sf", {63'd0, bus.sf}, {63'd0, sb[0].sf});
                checkOutput("of", {63'd0, bus.of}, {63'd0, sb[0].of});
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [3:0]  ic, fn;
        logic [63:0] a, b, c;
        tests    = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.icode = 4'h0; bus.ifun = 4'h0;
        bus.valA = '0; bus.valB = '0; bus.valC = '0;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        applyStimulus(1, 4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 1);
        applyStimulus(1, 4'h6, 4'h1, 64'd1, 64'h8000000000000000, 64'd0, 1);
        applyStimulus(1, 4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 1);
        applyStimulus(1, 4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 1);
        applyStimulus(1, 4'h6, 4'h3, 64'h55, 64'h55, 64'd0, 1);
        applyStimulus(1, 4'h2, 4'h4, 64'd9, 64'd0, 64'd0, 1);
        applyStimulus(0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 1);

        applyStimulus(1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 0);
        repeat (3) applyStimulus(1, 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 0);
        applyStimulus(1, 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 1);
        applyStimulus(0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1);

        doReset();
        applyStimulus(1, 4'h6, 4'h5, 64'd1, 64'd1, 64'd0, 1);
        applyStimulus(1, 4'hC, 4'h0, 64'd3, 64'd4, 64'd5, 1);
        applyStimulus(1, 4'h4, 4'h0, 64'd3, 64'h1000, 64'h20, 1);
        applyStimulus(1, 4'hB, 4'h0, 64'd3, 64'h1000, 64'h20, 1);

        applyStimulus(1, 4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 0);
        applyStimulus(0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 0);
        doReset();
        applyStimulus(0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1);

        for (int i = 0; i < 500; i++) begin
            ic = 4'($urandom_range(0, 13));
            if ($urandom_range(0, 5) == 0) fn = 4'($urandom_range(0, 15));
            else if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
            else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
            else fn = 4'h0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = b;
            if ($urandom_range(0, 3) == 0) a = {32'd0, $urandom} & 64'hFF;
            applyStimulus(1'($urandom_range(0, 3) != 0), ic, fn, a, b, c,
                          1'($urandom_range(0, 3) != 0));
        end

        repeat (3) applyStimulus(0, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
